// File: rtl/falafel_pkg.sv
// Shared falafel types and constants: word width, memory-op and responder-state encodings.
package falafel_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned MEM_WORD_BYTES = DATA_W / 8;

    // Sentinel key value used by allocator structures and their benches.
    localparam logic [DATA_W-1:0] EMPTY_KEY = '1;

    typedef enum logic [1:0] {
        MEM_LOAD  = 2'd0,
        MEM_STORE = 2'd1,
        MEM_CAS   = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } mem_rsp_state_e;

endpackage

// File: rtl/falafel_mem_sp_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, one-cycle read latency, contents never reset.
module falafel_mem_sp_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Reads and writes never share a cycle, so the read port is simply idle on writes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/falafel_mem_responder.sv
// Memory-side responder serving load/store/CAS on a local word array, one request at a time.
// Optional feature macro: FALAFEL_MEM_BOUNDS_CHECK_EN (adds mem_rsp_err_o and address checking).
module falafel_mem_responder
    import falafel_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = falafel_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic [DATA_W-1:0] mem_req_cas_exp_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    output logic              mem_rsp_err_o,
`endif
    output logic [DATA_W-1:0] mem_rsp_data_o
);

    localparam int unsigned WB = $clog2(DATA_W / 8);
    localparam int unsigned AW = $clog2(DEPTH);

    mem_rsp_state_e    state_q, state_d;
    mem_op_e           op_q, req_op;
    logic [AW-1:0]     idx_q, req_idx;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;

`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    logic              bad_q, req_bad;
    logic              rsp_err_q, rsp_err_d;

    assign req_bad = ((mem_req_addr_i >> (WB + AW)) != '0) || (mem_req_addr_i[WB-1:0] != '0);
    assign mem_rsp_err_o = rsp_err_q;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{mem_req_addr_i[DATA_W-1:WB+AW], mem_req_addr_i[WB-1:0]};
`endif

    assign req_idx = mem_req_addr_i[WB +: AW];
    assign req_op  = mem_req_is_cas_i   ? MEM_CAS   :
                     mem_req_is_write_i ? MEM_STORE : MEM_LOAD;

    assign mem_req_rdy_o  = (state_q == IDLE) && !rst_i;
    assign mem_rsp_val_o  = (state_q == RESPOND);
    assign mem_rsp_data_o = rsp_data_q;
    assign accept         = mem_req_val_i && mem_req_rdy_o;

    falafel_mem_sp_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        ram_we     = 1'b0;
        ram_addr   = req_idx;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = idx_q;
                state_d  = RESPOND;
                unique case (op_q)
                    MEM_STORE: begin
                        rsp_data_d = '0;
                        ram_we     = 1'b1;
                    end
                    MEM_CAS: begin
                        rsp_data_d = ram_rdata;
                        ram_we     = (ram_rdata == exp_q);
                    end
                    default: begin
                        rsp_data_d = ram_rdata;
                    end
                endcase
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
                rsp_err_d = bad_q;
                if (bad_q) begin
                    ram_we     = 1'b0;
                    rsp_data_d = '0;
                end
`endif
                // A reset landing in this cycle must not leave a half-done write behind.
                if (rst_i) begin
                    ram_we = 1'b0;
                end
            end
            RESPOND: begin
                if (mem_rsp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q   <= req_op;
            idx_q  <= req_idx;
            data_q <= mem_req_data_i;
            exp_q  <= mem_req_cas_exp_i;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
            bad_q  <= req_bad;
`endif
        end
    end

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed self-checking bench for falafel_mem_responder (honours FALAFEL_MEM_BOUNDS_CHECK_EN).
module tb_falafel_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_val_i;
    logic        mem_req_rdy_o;
    logic        mem_req_is_write_i;
    logic        mem_req_is_cas_i;
    logic [31:0] mem_req_addr_i;
    logic [31:0] mem_req_data_i;
    logic [31:0] mem_req_cas_exp_i;
    logic        mem_rsp_val_o;
    logic        mem_rsp_rdy_i;
    logic [31:0] mem_rsp_data_o;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    logic        mem_rsp_err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    falafel_mem_responder #(
        .DEPTH  (1024),
        .DATA_W (32)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_req_val_i      (mem_req_val_i),
        .mem_req_rdy_o      (mem_req_rdy_o),
        .mem_req_is_write_i (mem_req_is_write_i),
        .mem_req_is_cas_i   (mem_req_is_cas_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_data_i     (mem_req_data_i),
        .mem_req_cas_exp_i  (mem_req_cas_exp_i),
        .mem_rsp_val_o      (mem_rsp_val_o),
        .mem_rsp_rdy_i      (mem_rsp_rdy_i),
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
        .mem_rsp_err_o      (mem_rsp_err_o),
`endif
        .mem_rsp_data_o     (mem_rsp_data_o)
    );

    task automatic drive_req(input logic w, input logic c, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] x);
        mem_req_val_i      = 1'b1;
        mem_req_is_write_i = w;
        mem_req_is_cas_i   = c;
        mem_req_addr_i     = a;
        mem_req_data_i     = d;
        mem_req_cas_exp_i  = x;
    endtask

    // Full transaction: lat counts cycles from the accept cycle to the first rsp_val cycle.
    task automatic xact(input logic w, input logic c, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] x,
                        output logic [31:0] rd, output int lat, output logic err, output logic tmo);
        int n;
        tmo = 1'b0;
        err = 1'b0;
        drive_req(w, c, a, d, x);
        n = 0;
        while (mem_req_rdy_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1; n++;
        end
        if (n >= 20) tmo = 1'b1;
        @(posedge clk_i); #1;
        mem_req_val_i = 1'b0;
        lat = 1;
        while (mem_rsp_val_o !== 1'b1 && lat < 20) begin
            @(posedge clk_i); #1; lat++;
        end
        if (lat >= 20) tmo = 1'b1;
        rd = mem_rsp_data_o;
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
        err = mem_rsp_err_o;
`endif
        mem_rsp_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rsp_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_req_val_i = 1'b0; mem_req_is_write_i = 1'b0; mem_req_is_cas_i = 1'b0;
        mem_req_addr_i = '0; mem_req_data_i = '0; mem_req_cas_exp_i = '0;
        mem_rsp_rdy_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp_val got %b want 0", mem_rsp_val_o);
        end
        n_cmp++;
        if (mem_req_rdy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_req_rdy got %b want 0", mem_req_rdy_o);
        end
        n_cmp++;
        if (mem_rsp_data_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_rsp_data got %h want 0", mem_rsp_data_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (mem_req_rdy_o !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_req_rdy got %b want 1", mem_req_rdy_o);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b1, 1'b0, 32'h40, 32'hA5, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'h0 || tmo) begin
            n_bad++; $display("FAIL store_rsp_data got %h tmo %b want 0", rd, tmo);
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++; $display("FAIL store_latency got %0d want 2", lat);
        end
        xact(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL load_data got %h tmo %b want a5", rd, tmo);
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++; $display("FAIL load_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_cas_hit();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, rd, lat, err, tmo);
        xact(1'b1, 1'b1, 32'h0, 32'h7, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'h0 || tmo) begin
            n_bad++; $display("FAIL cas_hit_old got %h tmo %b want 0", rd, tmo);
        end
        xact(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'h7 || tmo) begin
            n_bad++; $display("FAIL cas_hit_written got %h tmo %b want 7", rd, tmo);
        end
    endtask

    task automatic test_cas_miss();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b0, 1'b1, 32'h40, 32'h7, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL cas_miss_old got %h tmo %b want a5", rd, tmo);
        end
        xact(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL cas_miss_unwritten got %h tmo %b want a5", rd, tmo);
        end
    endtask

    task automatic test_early_rsp_rdy();
        mem_rsp_rdy_i = 1'b1;
        drive_req(1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        mem_req_val_i = 1'b0;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b0 || mem_req_rdy_o !== 1'b0) begin
            n_bad++; $display("FAIL early_access_state got val %b rdy %b want 0 0", mem_rsp_val_o, mem_req_rdy_o);
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b1 || mem_rsp_data_o !== 32'hA5) begin
            n_bad++; $display("FAIL early_respond got val %b data %h want 1 a5", mem_rsp_val_o, mem_rsp_data_o);
        end
        @(posedge clk_i); #1;
        mem_rsp_rdy_i = 1'b0;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b0 || mem_req_rdy_o !== 1'b1) begin
            n_bad++; $display("FAIL early_handshake got val %b rdy %b want 0 1", mem_rsp_val_o, mem_req_rdy_o);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        // Hold a second load of word 0 pending through ACCESS/RESPOND.
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (mem_req_rdy_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_access_rdy got %b want 0", mem_req_rdy_o);
        end
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (mem_rsp_val_o !== 1'b1 || mem_rsp_data_o !== 32'hA5 || mem_req_rdy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d got val %b data %h rdy %b want 1 a5 0",
                         i, mem_rsp_val_o, mem_rsp_data_o, mem_req_rdy_o);
            end
            @(posedge clk_i); #1;
        end
        mem_rsp_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rsp_rdy_i = 1'b0;
        n_cmp++;
        if (mem_req_rdy_o !== 1'b1 || mem_rsp_val_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_after_hs got rdy %b val %b want 1 0", mem_req_rdy_o, mem_rsp_val_o);
        end
        @(posedge clk_i); #1;
        mem_req_val_i = 1'b0;
        n_cmp++;
        if (mem_req_rdy_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_second_accept got rdy %b want 0", mem_req_rdy_o);
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b1 || mem_rsp_data_o !== 32'h7) begin
            n_bad++; $display("FAIL bp_second_rsp got val %b data %h want 1 7", mem_rsp_val_o, mem_rsp_data_o);
        end
        mem_rsp_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        mem_rsp_rdy_i = 1'b0;
    endtask

    task automatic test_reset_in_access();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b1, 1'b0, 32'h80, 32'h33, 32'h0, rd, lat, err, tmo);
        drive_req(1'b1, 1'b0, 32'h80, 32'h55, 32'h0);
        @(posedge clk_i); #1;
        mem_req_val_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (mem_rsp_val_o !== 1'b0 || mem_req_rdy_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_access got val %b rdy %b want 0 0", mem_rsp_val_o, mem_req_rdy_o);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_req_rdy_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_access_idle got rdy %b want 1", mem_req_rdy_o);
        end
        xact(1'b0, 1'b0, 32'h80, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'h33 || tmo) begin
            n_bad++; $display("FAIL rst_write_suppressed got %h tmo %b want 33", rd, tmo);
        end
    endtask

`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
    task automatic test_bounds();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b1, 1'b0, 32'd4096, 32'h1, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0 || tmo) begin
            n_bad++; $display("FAIL oob_store got err %b data %h want 1 0", err, rd);
        end
        xact(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (err !== 1'b0 || rd !== 32'h7 || tmo) begin
            n_bad++; $display("FAIL oob_no_wrap_write got err %b data %h want 0 7", err, rd);
        end
        xact(1'b1, 1'b0, 32'h41, 32'h99, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (err !== 1'b1 || rd !== 32'h0 || tmo) begin
            n_bad++; $display("FAIL misaligned_store got err %b data %h want 1 0", err, rd);
        end
        xact(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (err !== 1'b0 || rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL misaligned_unwritten got err %b data %h want 0 a5", err, rd);
        end
    endtask
`else
    task automatic test_wrap();
        logic [31:0] rd; int lat; logic err, tmo;
        xact(1'b0, 1'b0, 32'h1040, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL wrap_load got %h want a5", rd);
        end
        xact(1'b0, 1'b0, 32'h43, 32'h0, 32'h0, rd, lat, err, tmo);
        n_cmp++;
        if (rd !== 32'hA5 || tmo) begin
            n_bad++; $display("FAIL unaligned_load got %h want a5", rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_cas_hit();
        test_cas_miss();
        test_early_rsp_rdy();
        test_back_to_back();
        test_reset_in_access();
`ifdef FALAFEL_MEM_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
